// File: rtl/fifo_wm.sv
// Purpose: DEPTH-entry FIFO plus a registered output word, with programmable almost-full/empty watermarks.
// Latency: a word written at edge N appears on dout after edge N+1 when the output register is empty.
// Backpressure: din_rdy comes from registered state and clear only; dout holds while dout_vld & ~dout_rdy.
// Optional feature: define FIFO_DROP_CNT_EN to add the saturating rejected-write counter drop_cnt.
module fifo_wm #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 24,
    parameter int DROP_W = 16,
    localparam int LW    = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             rstz,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    output logic             din_rdy,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    input  logic [LW-1:0]    afull_thresh,
    input  logic [LW-1:0]    aempty_thresh,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty
`ifdef FIFO_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0] drop_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrptr;
    logic [PW-1:0]    rdptr;
    logic [CW-1:0]    mem_cnt;
    logic             mem_full;
    logic             wr_en;
    logic             rd_en;
    logic [PW-1:0]    wrptr_nxt;
    logic [PW-1:0]    rdptr_nxt;

    assign mem_full = (mem_cnt == CW'(DEPTH));
    // Ready never looks at din_vld or dout_rdy, so a pop while full frees space one cycle later.
    assign din_rdy  = ~mem_full & ~clear;
    assign wr_en    = din_vld & din_rdy;
    // The output register refills whenever it is empty or being consumed this cycle.
    assign rd_en    = (~dout_vld | dout_rdy) & (mem_cnt != '0);

    // Pointers wrap by compare so DEPTH need not be a power of two.
    assign wrptr_nxt = (wrptr == PW'(DEPTH - 1)) ? '0 : wrptr + PW'(1);
    assign rdptr_nxt = (rdptr == PW'(DEPTH - 1)) ? '0 : rdptr + PW'(1);

    // Storage array: written on accepted writes, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wrptr] <= din;
        end
    end

    // Pointer, occupancy and output-stage state; reset and clear flush everything.
    always_ff @(posedge clk) begin
        if (!rstz || clear) begin
            wrptr    <= '0;
            rdptr    <= '0;
            mem_cnt  <= '0;
            dout_vld <= 1'b0;
            dout     <= '0;
        end else begin
            if (wr_en) begin
                wrptr <= wrptr_nxt;
            end
            if (rd_en) begin
                rdptr    <= rdptr_nxt;
                dout     <= mem[rdptr];
                dout_vld <= 1'b1;
            end else if (dout_vld && dout_rdy) begin
                dout_vld <= 1'b0;
            end
            case ({wr_en, rd_en})
                2'b10:   mem_cnt <= mem_cnt + CW'(1);
                2'b01:   mem_cnt <= mem_cnt - CW'(1);
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

    // Status flags follow the registered occupancy and the live thresholds in the same cycle.
    always_comb begin
        level        = LW'(mem_cnt) + LW'(dout_vld);
        full         = (level == LW'(DEPTH + 1));
        empty        = (level == '0);
        almost_full  = (level >= afull_thresh);
        almost_empty = (level <= aempty_thresh);
    end

`ifdef FIFO_DROP_CNT_EN
    // Count write attempts refused for lack of space; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rstz || clear) begin
            drop_cnt <= '0;
        end else if (din_vld && !din_rdy && (drop_cnt != {DROP_W{1'b1}})) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end
`else
    // Counter absent: keep DROP_W elaborated so both builds share one parameter list.
    logic [DROP_W-1:0] unused_drop_w;
    assign unused_drop_w = '0;
`endif

endmodule
